// File: rtl/fc_param_stream_buffer.sv
// rtl/fc_param_stream_buffer.sv - FC weight/bias store with valid/ready load and framed replay stream
module fc_param_stream_buffer #(
  parameter int BIT     = 32,
  parameter int IN_LEN  = 32,
  parameter int OUT_NEU = 10
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           wr_w_valid,
  input  logic [BIT-1:0] wr_w_data,
  output logic           wr_w_ready,
  input  logic           wr_b_valid,
  input  logic [BIT-1:0] wr_b_data,
  output logic           wr_b_ready,
  input  logic           clear,
  input  logic           start,
  output logic           loaded,
  output logic           busy,
  output logic           done,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [BIT-1:0] rd_weight,
  output logic [BIT-1:0] rd_bias,
  output logic           rd_first,
  output logic           rd_last,
  output logic           rd_end
);

  localparam int NW = IN_LEN * OUT_NEU;
  localparam int WA = $clog2(NW);
  localparam int NA = (OUT_NEU > 1) ? $clog2(OUT_NEU) : 1;
  localparam int KA = $clog2(IN_LEN);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_t;

  state_t state, state_nx;

  logic [BIT-1:0] w_mem [NW];
  logic [BIT-1:0] b_mem [OUT_NEU];

  logic [WA-1:0] w_cnt;
  logic [NA-1:0] b_cnt;
  logic          w_full, b_full;

  logic [WA-1:0] rd_addr;
  logic [NA-1:0] rd_n;
  logic [KA-1:0] rd_k;

  logic w_fire, b_fire, go, do_clear, adv, fin, k_wrap;

  assign wr_w_ready = (state == S_LOAD) && !w_full;
  assign wr_b_ready = (state == S_LOAD) && !b_full;

  always_comb begin
    w_fire   = wr_w_valid && wr_w_ready;
    b_fire   = wr_b_valid && wr_b_ready;
    go       = (state == S_READY) && start && !clear;
    do_clear = clear && (state != S_STREAM);
    adv      = (state == S_STREAM) && (!rd_valid || rd_ready);
    fin      = adv && rd_valid && rd_end;
    k_wrap   = (rd_k == KA'(IN_LEN - 1));
    state_nx = state;
    case (state)
      S_LOAD:   if (!clear && w_full && b_full) state_nx = S_READY;
      S_READY:  if (clear) state_nx = S_LOAD;
                else if (start) state_nx = S_STREAM;
      S_STREAM: if (fin) state_nx = S_READY;
      default:  state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_LOAD;
    else       state <= state_nx;
  end

  // Full flags, not counter values, mark a channel complete so counters stay NW/OUT_NEU-sized.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      w_cnt  <= '0;
      b_cnt  <= '0;
      w_full <= 1'b0;
      b_full <= 1'b0;
      loaded <= 1'b0;
    end else if (do_clear) begin
      w_cnt  <= '0;
      b_cnt  <= '0;
      w_full <= 1'b0;
      b_full <= 1'b0;
      loaded <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_cnt == WA'(NW - 1)) w_full <= 1'b1;
        else                      w_cnt  <= w_cnt + WA'(1);
      end
      if (b_fire) begin
        if (b_cnt == NA'(OUT_NEU - 1)) b_full <= 1'b1;
        else                           b_cnt  <= b_cnt + NA'(1);
      end
      if (state == S_LOAD && w_full && b_full) loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) w_mem[w_cnt] <= wr_w_data;
    if (b_fire) b_mem[b_cnt] <= wr_b_data;
  end

  // Read counters always point at the next beat to load; they rest at zero outside STREAM.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_valid  <= 1'b0;
      rd_weight <= '0;
      rd_bias   <= '0;
      rd_first  <= 1'b0;
      rd_last   <= 1'b0;
      rd_end    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      rd_n      <= '0;
      rd_k      <= '0;
    end else begin
      done <= fin;
      if (go) busy <= 1'b1;
      if (go || (adv && !rd_end)) begin
        rd_valid  <= 1'b1;
        rd_weight <= w_mem[rd_addr];
        rd_bias   <= b_mem[rd_n];
        rd_first  <= (rd_k == '0);
        rd_last   <= k_wrap;
        rd_end    <= k_wrap && (rd_n == NA'(OUT_NEU - 1));
        rd_addr   <= rd_addr + WA'(1);
        if (k_wrap) begin
          rd_k <= '0;
          rd_n <= rd_n + NA'(1);
        end else begin
          rd_k <= rd_k + KA'(1);
        end
      end else if (fin) begin
        rd_valid <= 1'b0;
        rd_first <= 1'b0;
        rd_last  <= 1'b0;
        rd_end   <= 1'b0;
        busy     <= 1'b0;
        rd_addr  <= '0;
        rd_n     <= '0;
        rd_k     <= '0;
      end
    end
  end

endmodule

// File: doc/fc_param_stream_buffer.md
Name: fc_param_stream_buffer

Overview:
- On-chip store for fully-connected layer weights and biases.
- Loaded once through valid/ready write ports, then replayed any number of times as an ordered weight stream with the matching bias attached.
- Sits between the parameter loader and the FC MAC datapath.
- Adds backpressure, replay, framing markers and controlled clear/reload.

Parameters:
- BIT, 32, word width of weights and biases.
- IN_LEN, 32, weights per output neuron (ROW*COL*CHANNEL of the feeding layer); must be >= 2.
- OUT_NEU, 10, number of output neurons / biases; must be >= 1.

Ports:
- clk  in  1  clock
- rst_  in  1  async reset, active low
- wr_w_valid  in  1  weight write beat valid
- wr_w_data  in  BIT  weight word, neuron-major order (neuron n, index k at address n*IN_LEN+k)
- wr_w_ready  out  1  weight write accepted this cycle
- wr_b_valid  in  1  bias write beat valid
- wr_b_data  in  BIT  bias word, neuron order
- wr_b_ready  out  1  bias write accepted this cycle
- clear  in  1  discard contents, return to LOAD
- start  in  1  request one full replay of the stream
- loaded  out  1  all weights and biases stored
- busy  out  1  replay in progress
- done  out  1  one-cycle pulse after last beat accepted
- rd_valid  out  1  stream beat valid
- rd_ready  in  1  consumer accepts beat
- rd_weight  out  BIT  weight of current beat
- rd_bias  out  BIT  bias of the neuron of current beat
- rd_first  out  1  beat is index 0 of a neuron
- rd_last  out  1  beat is index IN_LEN-1 of a neuron
- rd_end  out  1  beat is last of whole stream

Behaviour:
- Reset (async, rst_=0):
  - FSM=LOAD; all counters 0.
  - loaded, busy, done, rd_valid, rd_first, rd_last and rd_end are 0.
  - rd_weight and rd_bias are 0.
  - Memory contents are not cleared but are treated as invalid.
  - Reset mid-replay aborts the replay; no done pulse.
- Counters:
  - Write counters: weights 0..IN_LEN*OUT_NEU-1, biases 0..OUT_NEU-1.
  - Read counters: neuron 0..OUT_NEU-1, index 0..IN_LEN-1.
  - All counters are $clog2-sized.
- FSM LOAD:
  - wr_w_ready=1 until IN_LEN*OUT_NEU weights are stored.
  - wr_b_ready=1 until OUT_NEU biases are stored.
  - Weight and bias channels are independent; either may complete first.
  - A write happens on valid&&ready.
  - Beats offered after a channel is full see ready=0 and are dropped.
  - When both channels are full, the FSM moves to READY next cycle with loaded=1.
  - start in LOAD is ignored.
- FSM READY:
  - wr_*_ready=0.
  - start=1 moves the FSM to STREAM and sets busy=1.
  - The first beat (neuron 0, index 0) is presented with rd_valid=1 on the cycle after start is sampled (latency 1).
  - clear=1 sets loaded=0 and moves the FSM to LOAD with write counters reset.
  - If clear and start are asserted together, clear wins.
- FSM STREAM:
  - Outputs are registered.
  - The output register reloads when !rd_valid || rd_ready.
  - While rd_valid=1 && rd_ready=0, all rd_* outputs hold stable.
  - Beat order: neuron-major, index-minor.
  - rd_bias equals bias[neuron] for every beat of that neuron.
  - rd_first: index==0. rd_last: index==IN_LEN-1. rd_end: rd_last && neuron==OUT_NEU-1.
  - On acceptance of the rd_end beat:
    - rd_valid=0, busy=0 and done=1 for exactly one cycle.
    - The FSM returns to READY with loaded still 1, so replay is possible without reloading.
  - start and clear are ignored during STREAM; a clear is not queued.
- Throughput: one beat per cycle with rd_ready held high. A full replay is IN_LEN*OUT_NEU beats starting 1 cycle after start, so done rises IN_LEN*OUT_NEU+1 cycles after the start sample.
- Width: no arithmetic is performed on data; words pass bit-exact.

Test Plan:
- Test parameters: IN_LEN=4, OUT_NEU=3, BIT=32.
- Load and replay:
  - Stimulus: load weights 1..12 and biases 100,200,300 back-to-back, then pulse start with rd_ready=1.
  - Required: loaded=1 after the 12th weight and 3rd bias.
  - Required: 12 consecutive beats, weight 1..12, bias 100×4, 200×4, 300×4.
  - Required: rd_first at beats 1,5,9; rd_last at beats 4,8,12; rd_end at beat 12; done one cycle later.
- Backpressure:
  - Stimulus: toggle rd_ready 1,0,0,1 repeatedly during replay.
  - Required: rd_* hold through stall cycles; the sequence is identical to the load-and-replay case with no duplicates or drops.
- Overflow and order:
  - Stimulus: all 3 biases first, then 14 weight beats (weights 1..14).
  - Required: wr_b_ready falls after the 3rd bias; only weights 1..12 are stored; wr_w_ready=0 for beats 13–14; replay shows 12 as the final weight.
- Replay and clear:
  - Stimulus: second start after done.
  - Required: identical stream.
  - Stimulus: clear and start in the same cycle.
  - Required: loaded=0, no stream; a reload of weights 21..32 followed by start streams 21..32.
- Illegal starts:
  - Stimulus: start while in LOAD.
  - Required: no rd_valid.
  - Stimulus: start during STREAM.
  - Required: no restart; done fires once.
- Reset mid-stream:
  - Stimulus: rst_ low at beat 6.
  - Required: rd_valid, busy and loaded drop immediately; no done pulse; wr_w_ready=1 after release.
